// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: atan(2^-i) binary-angle table, 1/K gain constant
// and the FSM state type used by the rotation- and vectoring-mode engines.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DONE
  } cordic_state_e;

  localparam int ITER_CNT_W = 5;
  localparam int GUARD_W    = 4;
  localparam int Z_FRAC_W   = 4;

  // atan(2^-i) with 2^20 = 360 deg, i.e. a 16-bit binary angle with 4 fraction bits
  localparam int ATAN_W = 20;
  localparam int ATAN_N = 16;
  localparam logic [ATAN_W-1:0] ATAN_TABLE [ATAN_N] = '{
    20'd131072, 20'd77376, 20'd40884, 20'd20753,
    20'd10417,  20'd5213,  20'd2607,  20'd1304,
    20'd652,    20'd326,   20'd163,   20'd81,
    20'd41,     20'd20,    20'd10,    20'd5
  };

  // round(0.607253 * 2^15): reciprocal of the CORDIC gain in Q1.15
  localparam logic [15:0] INV_K_Q15 = 16'd19898;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, rescaled to the caller's angle accumulator width.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int OUT_W = ATAN_W
) (
  input  logic [ITER_CNT_W-1:0] idx,
  output logic [OUT_W-1:0]      atan_val
);

  logic [ATAN_W-1:0] raw;

  always_comb begin
    raw = '0;
    if (idx < ITER_CNT_W'(ATAN_N)) raw = ATAN_TABLE[idx[3:0]];
  end

  generate
    if (OUT_W >= ATAN_W) begin : g_wide
      assign atan_val = OUT_W'(raw) << (OUT_W - ATAN_W);
    end else begin : g_narrow
      assign atan_val = OUT_W'(raw >> (ATAN_W - OUT_W));
    end
  endgenerate

endmodule

// File: rtl/cordic_vectoring_16b.sv
// Vectoring-mode CORDIC: (x_in, y_in) -> magnitude and binary angle, one micro-rotation per clock.
// Optional macro CORDIC_GAIN_COMP_EN scales the magnitude by 1/K before it is presented.
module cordic_vectoring_16b
  import cordic_pkg::*;
#(
  parameter int width = 16,
  parameter int ITER  = 15
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] x_in,
  input  logic [width-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] magnitude,
  output logic [width-1:0] angle
);

  // x/y carry width+2 integer bits (headroom for -2^(width-1) and the gain) plus guard fraction bits
  localparam int XY_W   = width + 2 + GUARD_W;
  localparam int Z_W    = width + Z_FRAC_W;
  localparam int PROD_W = XY_W + 17;
  localparam logic signed [PROD_W-1:0] MAG_MAX = (PROD_W'(1) <<< width) - PROD_W'(1);

  cordic_state_e state_q, state_d;

  logic signed [XY_W-1:0]  x_p0, y_p0, x_cap, y_cap, x_shr, y_shr, x_nx, y_nx;
  logic        [Z_W-1:0]   z_p0, z_cap, z_nx, atan_val;
  logic [ITER_CNT_W-1:0]   iter_p0;
  logic                    zero_p0, last_iter;
  logic        [width-1:0] mag_p1, ang_p1;

  function automatic logic [width-1:0] mag_sat(input logic signed [XY_W-1:0] xv);
    logic signed [PROD_W-1:0] scaled;
`ifdef CORDIC_GAIN_COMP_EN
    scaled = (PROD_W'(xv) * PROD_W'($signed({1'b0, INV_K_Q15}))
              + (PROD_W'(1) <<< (14 + GUARD_W))) >>> (15 + GUARD_W);
`else
    scaled = (PROD_W'(xv) + (PROD_W'(1) <<< (GUARD_W - 1))) >>> GUARD_W;
`endif
    if (scaled[PROD_W-1])     mag_sat = '0;
    else if (scaled > MAG_MAX) mag_sat = '1;
    else                       mag_sat = scaled[width-1:0];
  endfunction

  function automatic logic [width-1:0] ang_round(input logic [Z_W-1:0] zv);
    logic [Z_W-1:0] zr;
    zr = zv + Z_W'(1 << (Z_FRAC_W - 1));
    return zr[Z_W-1:Z_FRAC_W];
  endfunction

  cordic_atan_rom #(.OUT_W(Z_W)) u_atan_rom (
    .idx      (iter_p0),
    .atan_val (atan_val)
  );

  // Capture: fold the left half-plane onto the right and start z at 180 deg
  always_comb begin
    x_cap = XY_W'($signed(x_in)) <<< GUARD_W;
    y_cap = XY_W'($signed(y_in)) <<< GUARD_W;
    z_cap = '0;
    if (x_in[width-1]) begin
      x_cap = -x_cap;
      y_cap = -y_cap;
      z_cap = {1'b1, {(Z_W-1){1'b0}}};
    end
  end

  // Micro-rotation i: steer y towards zero, accumulate the rotated angle in z
  always_comb begin
    x_shr = x_p0 >>> iter_p0;
    y_shr = y_p0 >>> iter_p0;
    if (y_p0[XY_W-1]) begin
      x_nx = x_p0 - y_shr;
      y_nx = y_p0 + x_shr;
      z_nx = z_p0 - atan_val;
    end else begin
      x_nx = x_p0 + y_shr;
      y_nx = y_p0 - x_shr;
      z_nx = z_p0 + atan_val;
    end
  end

  assign last_iter = (iter_p0 == ITER_CNT_W'(ITER - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_ROTATE;
      end
      ST_ROTATE: begin
        if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_p0    <= '0;
      y_p0    <= '0;
      z_p0    <= '0;
      iter_p0 <= '0;
      zero_p0 <= 1'b0;
      mag_p1  <= '0;
      ang_p1  <= '0;
    end else begin
      if (state_q == ST_IDLE && in_valid) begin
        x_p0    <= x_cap;
        y_p0    <= y_cap;
        z_p0    <= z_cap;
        iter_p0 <= '0;
        zero_p0 <= (x_in == '0) && (y_in == '0);
      end else if (state_q == ST_ROTATE) begin
        x_p0    <= x_nx;
        y_p0    <= y_nx;
        z_p0    <= z_nx;
        iter_p0 <= iter_p0 + ITER_CNT_W'(1);
        // Result registers load on the edge that enters DONE
        if (last_iter) begin
          mag_p1 <= mag_sat(x_nx);
          ang_p1 <= zero_p0 ? '0 : ang_round(z_nx);
        end
      end
    end
  end

  assign magnitude = mag_p1;
  assign angle     = ang_p1;

endmodule

// File: tb/tb_cordic_vectoring_16b.sv
// Bench for cordic_vectoring_16b: real-arithmetic polar model plus a handshake/latency model.
// Build with CORDIC_GAIN_COMP_EN defined to check the gain-compensated magnitude.
module tb_cordic_vectoring_16b;

  localparam int  ITER = 15;
  localparam real PI   = 3.14159265358979;

  logic        clock     = 1'b0;
  logic        resetn    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] x_in      = '0;
  logic [15:0] y_in      = '0;
  logic        in_ready, out_valid;
  logic [15:0] magnitude, angle;

  int  n_cmp = 0;
  int  n_bad = 0;
  real gain  = 1.0;

  int  cyc     = 0;
  int  done_at = 0;
  bit  pending = 1'b0;
  int  e_mag   = 0;
  int  e_ang   = 0;
  bit  e_zero  = 1'b0;

  bit          prev_valid = 1'b0;
  logic [15:0] prev_mag   = '0;
  logic [15:0] prev_ang   = '0;

  cordic_vectoring_16b #(.width(16), .ITER(ITER)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .angle     (angle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req, input int tol);
    n_cmp++;
    if (act - req > tol || req - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (tol %0d) at %0t", name, act, req, tol, $time);
    end
  endtask

  task automatic chk_ang(input int act, input int req);
    int d;
    d = act - req;
    if (d > 32767) d -= 65536;
    else if (d < -32768) d += 65536;
    n_cmp++;
    if (d > 3 || d < -3) begin
      n_bad++;
      $display("FAIL angle: got 0x%04h, required 0x%04h (tol 3) at %0t", act, req, $time);
    end
  endtask

  function automatic int model_ang(input int x, input int y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
    if (a < 0.0) a += 65536.0;
    return int'(a) % 65536;
  endfunction

  function automatic int model_mag(input int x, input int y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain;
`ifdef CORDIC_GAIN_COMP_EN
    m = m * 19898.0 / 32768.0;
`endif
    if (m > 65535.0) return 65535;
    return int'(m);
  endfunction

  // Transaction model: one vector in flight, result due ITER+1 cycles after its handshake cycle
  always @(posedge clock or negedge resetn) begin
    int xs, ys;
    if (!resetn) begin
      pending = 1'b0;
    end else begin
      if (pending && cyc >= done_at && out_ready) begin
        pending = 1'b0;
      end else if (!pending && in_valid) begin
        xs      = int'($signed(x_in));
        ys      = int'($signed(y_in));
        pending = 1'b1;
        done_at = cyc + 1 + ITER;
        e_zero  = (xs == 0) && (ys == 0);
        e_mag   = model_mag(xs, ys);
        e_ang   = model_ang(xs, ys);
      end
      cyc++;
    end
  end

  always @(negedge clock) begin
    bit ev;
    ev = resetn && pending && (cyc >= done_at);
    chk("out_valid", int'(out_valid), int'(ev), 0);
    chk("in_ready", int'(in_ready), int'(!pending), 0);
    if (!resetn) begin
      chk("reset_magnitude", int'(magnitude), 0, 0);
      chk("reset_angle", int'(angle), 0, 0);
    end else if (ev && out_valid) begin
      if (e_zero) begin
        chk("zero_vec_magnitude", int'(magnitude), 0, 0);
        chk("zero_vec_angle", int'(angle), 0, 0);
      end else begin
        chk("magnitude", int'(magnitude), e_mag, 3);
        chk_ang(int'(angle), e_ang);
      end
      if (prev_valid) begin
        chk("hold_magnitude", int'(magnitude), int'(prev_mag), 0);
        chk("hold_angle", int'(angle), int'(prev_ang), 0);
      end
    end
    prev_valid = out_valid && resetn;
    prev_mag   = magnitude;
    prev_ang   = angle;
  end

  task automatic issue(input int x, input int y);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clock); #1;
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 0, 1, 0);
    x_in     = 16'(x);
    y_in     = 16'(y);
    in_valid = 1'b1;
    @(negedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic await_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clock); #1;
      lat++;
    end
  endtask

  int vx [10] = '{1000, 0, -1000, 0,     1000, -32768, 3000,  -20000, 32767,  0};
  int vy [10] = '{0,    1000, 0, -1000,  1000, -32768, -4000, 15000,  -32768, 0};

  initial begin
    real p;
    int  lat, seen;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      gain = gain * $sqrt(1.0 + p);
      p    = p / 4.0;
    end

    chk("model_ang_east",  model_ang(1000, 0),       0,     0);
    chk("model_ang_north", model_ang(0, 1000),       16384, 0);
    chk("model_ang_west",  model_ang(-1000, 0),      32768, 0);
    chk("model_ang_south", model_ang(0, -1000),      49152, 0);
    chk("model_ang_ne",    model_ang(1000, 1000),    8192,  0);
    chk("model_ang_sw",    model_ang(-32768, -32768), 40960, 0);
`ifdef CORDIC_GAIN_COMP_EN
    chk("model_mag_1000",  model_mag(1000, 0),       1000,  0);
    chk("model_mag_5000",  model_mag(3000, -4000),   5000,  0);
    chk("model_mag_max",   model_mag(-32768, -32768), 46340, 0);
`else
    chk("model_mag_1000",  model_mag(1000, 0),       1647,  0);
    chk("model_mag_5000",  model_mag(3000, -4000),   8234,  0);
    chk("model_mag_max",   model_mag(-32768, -32768), 65535, 0);
`endif

    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock); #1;

    for (int k = 0; k < 10; k++) begin
      issue(vx[k], vy[k]);
      await_result(lat);
      chk("latency", lat, ITER + 1, 0);
      @(negedge clock); #1;
    end

    // Consumer stalls for 10 cycles, then a one-cycle out_ready pulse
    out_ready = 1'b0;
    issue(1000, 1000);
    await_result(lat);
    chk("latency_stalled", lat, ITER + 1, 0);
    repeat (10) begin
      @(negedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock); #1;
    chk("idle_after_pulse", int'(out_valid), 0, 0);
    chk("ready_after_pulse", int'(in_ready), 1, 0);

    // Reset during iteration 7 must drop the vector
    issue(1000, 0);
    repeat (7) begin
      @(negedge clock); #1;
    end
    resetn = 1'b0;
    @(negedge clock); #2;
    resetn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clock); #1;
      if (out_valid) seen++;
    end
    chk("no_result_after_reset", seen, 0, 0);

    issue(0, 0);
    await_result(lat);
    chk("latency_zero", lat, ITER + 1, 0);
    chk("zero_magnitude", int'(magnitude), 0, 0);
    chk("zero_angle", int'(angle), 0, 0);
    @(negedge clock); #1;

    // Reset while a result waits in DONE
    out_ready = 1'b0;
    issue(3000, -4000);
    await_result(lat);
    chk("latency_done_reset", lat, ITER + 1, 0);
    resetn = 1'b0;
    @(negedge clock); #2;
    resetn    = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clock); #1;
      if (out_valid) seen++;
    end
    chk("no_result_after_done_reset", seen, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_vectoring_16b.md
CORDIC_VECTORING_16B -- requirements
Module: cordic_vectoring_16b

Interface
REQ-001 SHALL have parameter width, default 16, the sample, magnitude and angle width in bits.
REQ-002 SHALL have parameter ITER, default 15, the number of CORDIC micro-rotations (1..width-1).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning x_in/y_in carry a vector to convert.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a vector this cycle.
REQ-007 SHALL have ports x_in and y_in, input, width, signed two's-complement Cartesian coordinates.
REQ-008 SHALL have port out_valid, output, 1, meaning magnitude/angle hold a completed result.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 SHALL have port magnitude, output, width, unsigned vector length.
REQ-011 SHALL have port angle, output, width, binary angle (2^width = 360 deg, 0x4000 = 90 deg at width 16), same format the angle generator produces.

Function
REQ-012 SHALL implement vectoring-mode CORDIC (inverse of the rotation-mode sine/cosine generator): drive y to 0, accumulate z.
REQ-013 SHALL use FSM IDLE -> ROTATE -> DONE -> IDLE; no other states.
REQ-014 IDLE: in_ready=1; in_valid&in_ready captures x_in/y_in and enters ROTATE next cycle.
REQ-015 Capture SHALL pre-rotate: x_in<0 -> x=-x, y=-y, z=2^(width-1) (180 deg); else z=0.
REQ-016 Internal x/y datapath SHALL be width+2 bits signed so -2^(width-1) inputs and CORDIC gain cannot overflow.
REQ-017 ROTATE: iteration i=0..ITER-1 one per clock; y>=0 -> x+=y>>>i, y-=x>>>i, z+=atan(2^-i); else opposite signs; arithmetic shifts.
REQ-018 After iteration ITER-1 SHALL enter DONE; out_valid=1 in DONE only; latency capture-to-out_valid exactly ITER+1 cycles.
REQ-019 DONE: magnitude/angle SHALL stay stable while out_ready=0; out_valid&out_ready -> IDLE next cycle.
REQ-020 in_ready SHALL be 0 in ROTATE and DONE; throughput one vector per ITER+2 cycles.
REQ-021 angle SHALL wrap modulo 2^width (negative result reported as its two's-complement, e.g. -90 deg = 0xC000).
REQ-022 x_in=y_in=0 SHALL yield magnitude=0, angle=0.
REQ-023 magnitude SHALL saturate to 2^width-1 if the scaled result exceeds it.

Reset
REQ-024 resetn=0 SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, magnitude=0, angle=0, and clear x/y/z/iteration counter.
REQ-025 Reset asserted mid-ROTATE or in DONE SHALL discard the operation; no result emitted after release.

Configuration
REQ-026 Macro CORDIC_GAIN_COMP_EN defined: magnitude SHALL be multiplied by 1/K (constant round(0.607253*2^15)=19898, product >>15) in the DONE-entry cycle, latency unchanged.
REQ-027 Macro CORDIC_GAIN_COMP_EN undefined: magnitude SHALL be the raw x (approx 1.6468*|v|), no multiplier instantiated.

Structure
REQ-028 Shared package cordic_pkg SHALL hold the atan(2^-i) binary-angle table, 1/K constant and the FSM state typedef, shared with the rotation-mode CORDIC.
REQ-029 One sub-module cordic_atan_rom (index in, angle constant out, combinational) SHALL supply z increments.

Verification
REQ-030 (1000,0) -> angle 0x0000 +/-3 LSB; magnitude 1647 +/-3 (comp off) or 1000 +/-3 (comp on), out_valid exactly 16 cycles after capture.
REQ-031 (0,1000), (-1000,0), (0,-1000) -> angle 0x4000, 0x8000, 0xC000 +/-3 LSB, same magnitude as REQ-030.
REQ-032 (1000,1000) -> angle 0x2000 +/-3; (-32768,-32768) -> angle 0xA000 +/-3, no overflow, magnitude saturated when comp off.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; pulse out_ready -> IDLE next cycle.
REQ-034 resetn low at iteration 7 -> out_valid never rises for that vector; next vector (0,0) -> magnitude 0, angle 0.
